// File: rtl/alu_pipe_seq_pkg.sv
// ============================================================================
// Module : alu_pipe_seq_pkg
// Brief  : Shared opcode/state enums and default width for alu_pipe_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pipe_seq_pkg;

    localparam int ALU_W_DEFAULT = 8;

    typedef enum logic [3:0] {
        kSUB  = 4'd0,
        kPAR  = 4'd1,
        kADD  = 4'd2,
        kXOR  = 4'd3,
        kLSOR = 4'd4,
        kSHL  = 4'd5,
        kSHR  = 4'd6
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_shift_unit.sv
// ============================================================================
// Module : alu_shift_unit
// Brief  : Loadable W-bit shift register with down-counter, one bit per step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shift_unit #(
    parameter int W   = 8,
    parameter int SHW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_dir,     // 1 = logical right, 0 = left
    input  logic [W-1:0]   i_data,
    input  logic [SHW-1:0] i_amt,
    output logic [W-1:0]   o_next,
    output logic           o_last
);

    logic [W-1:0]   r_data;
    logic [SHW-1:0] r_cnt;
    logic           r_dir;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_cnt  <= i_amt;
            r_dir  <= i_dir;
        end else if (i_step) begin
            r_data <= o_next;
            r_cnt  <= r_cnt - 1'b1;
        end
    end

    assign o_next = r_dir ? {1'b0, r_data[W-1:1]} : {r_data[W-2:0], 1'b0};
    // Count of 0 or 1 means the step in progress is the final one.
    assign o_last = (r_cnt[SHW-1:1] == '0);

endmodule

`default_nettype wire

// File: rtl/alu_pipe_seq.sv
// ============================================================================
// Module : alu_pipe_seq
// Brief  : W-bit ALU with registered result, valid/ready handshake and
//          iterative SHL/SHR. Macro ALU_CARRY_EN adds Carry/Overflow outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_pipe_seq
    import alu_pipe_seq_pkg::*;
#(
    parameter int W = ALU_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [3:0]   i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_out,
    output logic         o_zero,
    output logic         o_parity
`ifdef ALU_CARRY_EN
    ,
    output logic         o_carry,
    output logic         o_overflow
`endif
);

    localparam int SHW = $clog2(W);

    alu_state_t     r_state, w_next;
    logic [W-1:0]   w_add, w_sub, w_res, w_fin, w_sh_next;
    logic [SHW-1:0] w_amt;
    logic           w_accept, w_is_shift, w_load_res, w_sh_load, w_sh_step, w_sh_last;

    assign w_amt      = i_b[SHW-1:0];
    assign w_is_shift = (i_op == kSHL) || (i_op == kSHR);
    assign o_ready    = rst_n && ((r_state == IDLE) || ((r_state == DONE) && i_ready));
    assign o_valid    = (r_state == DONE);
    assign w_accept   = i_valid && o_ready;

`ifdef ALU_CARRY_EN
    logic w_add_c, w_sub_c, w_c, w_v, w_c_fin, w_v_fin, r_carry, r_overflow;
    assign {w_add_c, w_add} = {1'b0, i_a} + {1'b0, i_b};
    assign {w_sub_c, w_sub} = {1'b0, i_a} + {1'b0, ~i_b} + (W+1)'(1);
`else
    assign w_add = i_a + i_b;
    assign w_sub = i_a - i_b;
`endif

    always_comb begin
        w_res = '0;
`ifdef ALU_CARRY_EN
        w_c = 1'b0;
        w_v = 1'b0;
`endif
        case (i_op)
            kSUB: begin
                w_res = w_sub;
`ifdef ALU_CARRY_EN
                w_c = w_sub_c;
                w_v = (i_a[W-1] ^ i_b[W-1]) & (w_sub[W-1] ^ i_a[W-1]);
`endif
            end
            kPAR: w_res = {{(W-1){1'b0}}, ^i_a};
            kADD: begin
                w_res = w_add;
`ifdef ALU_CARRY_EN
                w_c = w_add_c;
                w_v = ~(i_a[W-1] ^ i_b[W-1]) & (w_add[W-1] ^ i_a[W-1]);
`endif
            end
            kXOR:  w_res = i_a ^ i_b;
            kLSOR: w_res = {1'b0, {i_a[W-3:0], 1'b0} | i_b[W-2:0]};
            kSHL, kSHR: w_res = i_a;   // zero-distance shift completes immediately
            default: w_res = '0;
        endcase
    end

    always_comb begin
        w_next     = r_state;
        w_load_res = 1'b0;
        w_sh_load  = 1'b0;
        w_sh_step  = 1'b0;
        w_fin      = w_res;
`ifdef ALU_CARRY_EN
        w_c_fin    = w_c;
        w_v_fin    = w_v;
`endif
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_amt != '0)) begin
                        w_next    = BUSY;
                        w_sh_load = 1'b1;
                    end else begin
                        w_next     = DONE;
                        w_load_res = 1'b1;
                    end
                end else if ((r_state == DONE) && i_ready) begin
                    w_next = IDLE;
                end
            end
            BUSY: begin
                w_sh_step = 1'b1;
                if (w_sh_last) begin
                    w_next     = DONE;
                    w_load_res = 1'b1;
                    w_fin      = w_sh_next;
`ifdef ALU_CARRY_EN
                    w_c_fin    = 1'b0;
                    w_v_fin    = 1'b0;
`endif
                end
            end
            default: w_next = IDLE;
        endcase
    end

    alu_shift_unit #(.W(W), .SHW(SHW)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_sh_load),
        .i_step (w_sh_step),
        .i_dir  (i_op == kSHR),
        .i_data (i_a),
        .i_amt  (w_amt),
        .o_next (w_sh_next),
        .o_last (w_sh_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            o_out    <= '0;
            o_zero   <= 1'b0;
            o_parity <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load_res) begin
                o_out    <= w_fin;
                o_zero   <= ~|w_fin;
                o_parity <= ^w_fin;
            end
        end
    end

`ifdef ALU_CARRY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_load_res) begin
            r_carry    <= w_c_fin;
            r_overflow <= w_v_fin;
        end
    end
    assign o_carry    = r_carry;
    assign o_overflow = r_overflow;
`endif

endmodule

`default_nettype wire
